// File: rtl/fpu_div16.sv
// fp16 divider fpuIn1 / fpuIn2: radix-2 restoring, RNE rounding, subnormals flushed to zero.
// Latency: 16 clocks from the start edge for normal operands, 1 clock for special cases.
// Backpressure: none. start is accepted only in IDLE/DONE. fpuOut/condCodes hold until the next result.

package fpu_div16_pkg;
    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    typedef struct packed {
        logic z;    // result is +/-0
        logic c;    // inexact (rounded or flushed)
        logic n;    // result sign
        logic v;    // exponent all ones (Inf/NaN)
    } condCode_t;
endpackage

module fpu_div16
    import fpu_div16_pkg::*;
#(
    parameter int QBITS = 14
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      start,
    input  fp16_t     fpuIn1,
    input  fp16_t     fpuIn2,
    output fp16_t     fpuOut,
    output logic      done,
    output condCode_t condCodes
);

    localparam int CW = $clog2(QBITS);
    localparam logic [CW-1:0] LAST_ITER = CW'(QBITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

    state_t             r_state;
    fp16_t              r_a;
    fp16_t              r_b;
    logic               r_sign;
    logic signed [6:0]  r_exp;
    logic [10:0]        r_mb;
    logic [11:0]        r_rem;
    logic [QBITS-1:0]   r_q;
    logic [CW-1:0]      r_cnt;
    fp16_t              r_out;
    condCode_t          r_cc;
    logic               r_done;

    // Operand decode and special-case resolution
    logic              w_special;
    fp16_t             w_spec_out;
    condCode_t         w_spec_cc;
    logic              w_sign;
    logic signed [6:0] w_exp;
    logic [10:0]       w_ma;
    logic [10:0]       w_mb;

    // Decode captured operands; special cases resolve straight to a result.
    always_comb begin
        logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        nan_a      = (r_a.exp == 5'h1F) && (r_a.frac != 10'd0);
        nan_b      = (r_b.exp == 5'h1F) && (r_b.frac != 10'd0);
        inf_a      = (r_a.exp == 5'h1F) && (r_a.frac == 10'd0);
        inf_b      = (r_b.exp == 5'h1F) && (r_b.frac == 10'd0);
        zero_a     = (r_a.exp == 5'd0);
        zero_b     = (r_b.exp == 5'd0);
        w_sign     = r_a.sign ^ r_b.sign;
        w_ma       = {1'b1, r_a.frac};
        w_mb       = {1'b1, r_b.frac};
        w_exp      = $signed({2'b00, r_a.exp}) - $signed({2'b00, r_b.exp}) + 7'sd15;
        w_special  = 1'b1;
        w_spec_out = '0;
        w_spec_cc  = '0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            w_spec_out = 16'h7E00;
            w_spec_cc  = '{z: 1'b0, c: 1'b0, n: 1'b0, v: 1'b1};
        end else if (inf_a || zero_b) begin
            w_spec_out = '{sign: w_sign, exp: 5'h1F, frac: 10'd0};
            w_spec_cc  = '{z: 1'b0, c: 1'b0, n: w_sign, v: 1'b1};
        end else if (inf_b || zero_a) begin
            w_spec_out = '{sign: w_sign, exp: 5'd0, frac: 10'd0};
            w_spec_cc  = '{z: 1'b1, c: 1'b0, n: w_sign, v: 1'b0};
        end else begin
            w_special = 1'b0;
        end
    end

    // One restoring step: compare, conditionally subtract, emit a quotient bit.
    logic        w_ge;
    logic [10:0] w_rem_sub;
    assign w_ge      = r_rem >= {1'b0, r_mb};
    assign w_rem_sub = w_ge ? 11'(r_rem - {1'b0, r_mb}) : r_rem[10:0];

    // Normalise, round to nearest even and range-check the final quotient.
    fp16_t     w_res_out;
    condCode_t w_res_cc;
    always_comb begin
        logic [QBITS-1:0]  qn;
        logic signed [6:0] en;
        logic signed [6:0] ef;
        logic [10:0]       mant;
        logic [11:0]       mant_r;
        logic [9:0]        frac;
        logic              guard, sticky, up;
        qn     = r_q[QBITS-1] ? r_q : {r_q[QBITS-2:0], 1'b0};
        en     = r_q[QBITS-1] ? r_exp : r_exp - 7'sd1;
        mant   = qn[QBITS-1:QBITS-11];
        guard  = qn[QBITS-12];
        sticky = (|qn[QBITS-13:0]) | (|r_rem);
        up     = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + 12'(up);
        // A carry out of the mantissa leaves 1.000..., so the dropped bit is always 0.
        frac   = mant_r[11] ? mant_r[10:1] : mant_r[9:0];
        ef     = mant_r[11] ? en + 7'sd1 : en;
        if (ef >= 7'sd31) begin
            w_res_out = '{sign: r_sign, exp: 5'h1F, frac: 10'd0};
            w_res_cc  = '{z: 1'b0, c: 1'b1, n: r_sign, v: 1'b1};
        end else if (ef <= 7'sd0) begin
            w_res_out = '{sign: r_sign, exp: 5'd0, frac: 10'd0};
            w_res_cc  = '{z: 1'b1, c: 1'b1, n: r_sign, v: 1'b0};
        end else begin
            w_res_out = '{sign: r_sign, exp: ef[4:0], frac: frac};
            w_res_cc  = '{z: 1'b0, c: guard | sticky, n: r_sign, v: 1'b0};
        end
    end

    // Control FSM and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_mb    <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_cc    <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= fpuIn1;
                        r_b     <= fpuIn2;
                        r_done  <= 1'b0;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sign <= w_sign;
                    r_exp  <= w_exp;
                    r_mb   <= w_mb;
                    r_rem  <= {1'b0, w_ma};
                    r_q    <= '0;
                    r_cnt  <= '0;
                    if (w_special) begin
                        r_out   <= w_spec_out;
                        r_cc    <= w_spec_cc;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_rem <= {w_rem_sub, 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_out   <= w_res_out;
                    r_cc    <= w_res_cc;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fpuOut    = r_out;
    assign condCodes = r_cc;
    assign done      = r_done;

endmodule
